// File: rtl/song_reader.sv
// song_reader: walks the note list of the selected song in a synchronous
// song ROM and hands each {note, duration} pair to the note player
// controller with a one-cycle new_note pulse, advancing on note_done.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   play       play enable (level); low pauses, low in END returns to IDLE
//   song       song select
//   note_done  one-cycle pulse from the controller when a note finishes
//   rom_addr   {cur_song, note_idx}, combinational from registers
//   rom_data   {note, duration} from the ROM, valid one cycle after rom_addr
//   new_note   one-cycle pulse, note/duration valid with it
//   note       registered note code
//   duration   registered duration
//   song_done  end-of-song flag
//
// Optional build macro SONG_READER_LOOP_EN: the song repeats instead of
// stopping in END; song_done becomes a one-cycle pulse per pass. An end
// marker at index 0 still parks in END so an empty song cannot spin.
module song_reader #(
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned SONG_W = 2,
  parameter int unsigned NOTE_W = 6,
  parameter int unsigned DUR_W  = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic [SONG_W-1:0]         song,
  input  logic                      note_done,
  output logic [SONG_W+IDX_W-1:0]   rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]   rom_data,
  output logic                      new_note,
  output logic [NOTE_W-1:0]         note,
  output logic [DUR_W-1:0]          duration,
  output logic                      song_done
);

  localparam int unsigned NOTES_PER_SONG = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTES_PER_SONG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EMIT,
    S_WAIT,
    S_END
  } state_t;

  state_t              state;
  logic [SONG_W-1:0]   cur_song;
  logic [IDX_W-1:0]    note_idx;

  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;
  logic                song_change;
  logic                paused;

  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];
  assign rom_addr = {cur_song, note_idx};

  // Song change wins over pause; END is not a pausable state (play low exits it).
  assign song_change = (state != S_IDLE) && play && (song != cur_song);
  assign paused      = !play && (state inside {S_FETCH, S_EMIT, S_WAIT});

  // Sequencer: new_note and song_done default low each cycle and are only
  // re-asserted by the transitions (or END residency) that call for them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_song  <= '0;
      note_idx  <= '0;
      new_note  <= 1'b0;
      note      <= '0;
      duration  <= '0;
      song_done <= 1'b0;
    end else begin
      new_note  <= 1'b0;
      song_done <= 1'b0;
      if (song_change) begin
        cur_song <= song;
        note_idx <= '0;
        state    <= S_FETCH;
      end else if (paused) begin
        state <= state;
      end else begin
        case (state)
          S_IDLE: begin
            if (play) begin
              cur_song <= song;
              note_idx <= '0;
              state    <= S_FETCH;
            end
          end
          // One cycle for the ROM to present the addressed entry.
          S_FETCH: state <= S_EMIT;
          S_EMIT: begin
            if (rom_dur == '0) begin
`ifdef SONG_READER_LOOP_EN
              song_done <= 1'b1;
              if (note_idx == '0) begin
                state <= S_END;
              end else begin
                note_idx <= '0;
                state    <= S_FETCH;
              end
`else
              song_done <= 1'b1;
              state     <= S_END;
`endif
            end else begin
              note     <= rom_note;
              duration <= rom_dur;
              new_note <= 1'b1;
              state    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (note_done) begin
              if (note_idx == LAST_IDX) begin
                song_done <= 1'b1;
`ifdef SONG_READER_LOOP_EN
                note_idx <= '0;
                state    <= S_FETCH;
`else
                state    <= S_END;
`endif
              end else begin
                note_idx <= note_idx + 1'b1;
                state    <= S_FETCH;
              end
            end
          end
          S_END: begin
            if (!play) begin
              note_idx <= '0;
              state    <= S_IDLE;
            end else begin
              song_done <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader: a behavioural synchronous ROM feeds the
// DUT; each step is checked one time unit after the rising edge.
module tb_song_reader;

  logic        clk;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic        new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        song_done;

  logic [11:0] mem [128];
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  int          p0;

  song_reader dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .song      (song),
    .note_done (note_done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .new_note  (new_note),
    .note      (note),
    .duration  (duration),
    .song_done (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  always @(negedge clk) if (new_note === 1'b1) pulses <= pulses + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // From FETCH: EMIT cycle (no pulse), then the new_note cycle.
  task automatic take_note(input string tag, input logic [5:0] en, input logic [5:0] ed);
    step();
    chk({tag, " emit new_note"}, 32'(new_note), 32'd0);
    step();
    chk({tag, " new_note"}, 32'(new_note), 32'd1);
    chk({tag, " note"}, 32'(note), 32'(en));
    chk({tag, " duration"}, 32'(duration), 32'(ed));
  endtask

  task automatic done_pulse();
    note_done = 1'b1;
    step();
    note_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    play = 1'b0;
    song = 2'd0;
    note_done = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 12'h000;

    // Reset values
    step();
    step();
    chk("rst new_note", 32'(new_note), 32'd0);
    chk("rst note", 32'(note), 32'd0);
    chk("rst duration", 32'(duration), 32'd0);
    chk("rst song_done", 32'(song_done), 32'd0);
    chk("rst rom_addr", 32'(rom_addr), 32'd0);
    reset = 1'b0;

    // Song 1: three notes then end marker at index 3
    mem[{2'd1, 5'd0}] = {6'd20, 6'd8};
    mem[{2'd1, 5'd1}] = {6'd5, 6'd3};
    mem[{2'd1, 5'd2}] = {6'd7, 6'd9};
    mem[{2'd1, 5'd3}] = {6'd33, 6'd0};
    for (int i = 0; i < 32; i++) mem[{2'd3, 5'(i)}] = {6'(i + 1), 6'd1};

    step();
    p0 = pulses;
    play = 1'b1;
    song = 2'd1;
    step();
    chk("s1 rom_addr", 32'(rom_addr), 32'h20);
    take_note("s1n0", 6'd20, 6'd8);
    for (int j = 0; j < 4; j++) begin
      step();
      chk("s1n0 gap", 32'(new_note), 32'd0);
    end
    done_pulse();
    take_note("s1n1", 6'd5, 6'd3);
    for (int j = 0; j < 4; j++) step();
    done_pulse();
    take_note("s1n2", 6'd7, 6'd9);
    for (int j = 0; j < 4; j++) step();
    done_pulse();
    step();
    chk("s1 end early song_done", 32'(song_done), 32'd0);
    step();
    chk("s1 song_done", 32'(song_done), 32'd1);
    chk("s1 end new_note", 32'(new_note), 32'd0);
    chk("s1 end note", 32'(note), 32'd7);
    chk("s1 end duration", 32'(duration), 32'd9);
    step();
    step();
    chk("s1 song_done held", 32'(song_done), 32'd1);
    chk("s1 pulse count", 32'(pulses - p0), 32'd3);
    play = 1'b0;
    step();
    chk("s1 idle song_done", 32'(song_done), 32'd0);
    chk("s1 idle rom_addr", 32'(rom_addr), 32'h20);

    // Song 3: 32 nonzero entries, note_done coincident with new_note
    step();
    p0 = pulses;
    song = 2'd3;
    play = 1'b1;
    step();
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("s3 addr %0d", i), 32'(rom_addr), 32'(7'h60 + 7'(i)));
      take_note($sformatf("s3n%0d", i), 6'(i + 1), 6'd1);
      done_pulse();
    end
    chk("s3 song_done", 32'(song_done), 32'd1);
    chk("s3 end addr", 32'(rom_addr), 32'h7f);
    for (int j = 0; j < 6; j++) step();
    chk("s3 no 33rd note", 32'(pulses - p0), 32'd32);
    chk("s3 song_done held", 32'(song_done), 32'd1);
    play = 1'b0;
    step();

    // Pause in WAIT_DONE at index 4, note_done ignored while paused
    song = 2'd3;
    play = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      take_note($sformatf("p n%0d", i), 6'(i + 1), 6'd1);
      done_pulse();
    end
    take_note("p n4", 6'd5, 6'd1);
    play = 1'b0;
    for (int j = 0; j < 10; j++) begin
      note_done = (j == 4);
      step();
      chk("pause new_note", 32'(new_note), 32'd0);
    end
    note_done = 1'b0;
    chk("pause addr", 32'(rom_addr), 32'h64);
    play = 1'b1;
    step();
    step();
    chk("resume addr", 32'(rom_addr), 32'h64);
    chk("resume new_note", 32'(new_note), 32'd0);
    done_pulse();
    chk("resume advance", 32'(rom_addr), 32'h65);
    take_note("p n5", 6'd6, 6'd1);

    // Song change from 1 to 2 at index 7
    reset = 1'b1;
    play = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mem[{2'd1, 5'(i)}] = {6'(i + 10), 6'd2};
    mem[{2'd2, 5'd0}] = {6'd42, 6'd17};
    song = 2'd1;
    play = 1'b1;
    step();
    chk("sc start addr", 32'(rom_addr), 32'h20);
    for (int i = 0; i < 7; i++) begin
      take_note($sformatf("sc n%0d", i), 6'(i + 10), 6'd2);
      done_pulse();
    end
    take_note("sc n7", 6'd17, 6'd2);
    chk("sc addr7", 32'(rom_addr), 32'h27);
    song = 2'd2;
    step();
    chk("sc switch addr", 32'(rom_addr), 32'h40);
    chk("sc switch new_note", 32'(new_note), 32'd0);
    take_note("sc s2n0", 6'd42, 6'd17);

    // Reset while in WAIT_DONE with new_note high
    reset = 1'b1;
    step();
    chk("mid rst new_note", 32'(new_note), 32'd0);
    chk("mid rst note", 32'(note), 32'd0);
    chk("mid rst duration", 32'(duration), 32'd0);
    chk("mid rst song_done", 32'(song_done), 32'd0);
    chk("mid rst rom_addr", 32'(rom_addr), 32'd0);
    play = 1'b0;
    reset = 1'b0;
    step();

`ifdef SONG_READER_LOOP_EN
    // Two-note song repeats; song_done pulses once per pass
    mem[{2'd0, 5'd0}] = {6'd1, 6'd4};
    mem[{2'd0, 5'd1}] = {6'd2, 6'd4};
    mem[{2'd0, 5'd2}] = {6'd0, 6'd0};
    song = 2'd0;
    play = 1'b1;
    step();
    for (int pass = 0; pass < 2; pass++) begin
      take_note("loop n0", 6'd1, 6'd4);
      done_pulse();
      take_note("loop n1", 6'd2, 6'd4);
      done_pulse();
      step();
      step();
      chk("loop song_done pulse", 32'(song_done), 32'd1);
      chk("loop restart addr", 32'(rom_addr), 32'h00);
    end
    take_note("loop n0 again", 6'd1, 6'd4);
    chk("loop song_done cleared", 32'(song_done), 32'd0);
    reset = 1'b1;
    step();
    chk("loop rst new_note", 32'(new_note), 32'd0);
    chk("loop rst note", 32'(note), 32'd0);
    chk("loop rst song_done", 32'(song_done), 32'd0);
    reset = 1'b0;
    play = 1'b0;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
